img_vector_reader: RTL and testbench

//  Reader side of the ROM image store: given an image start address (ADR_*_START from img_pkg)

---
 rtl/img_vector_reader.sv | 185 ++++++++++++++++++
 tb/tb_img_vector_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/img_vector_reader.sv
// img_vector_reader
//   Walks an image's point list in a synchronous ROM, translates every point
//   from image-local to screen coordinates (s = pos + p - mid) and presents it
//   downstream on a valid/ready handshake. A run stops at the word carrying
//   the end flag, or after MAX_POINTS words (overrun, err_overrun set).
//
//   Optional feature macro: IMG_READER_CLIP_EN
//     defined   : off-screen results clamp to 0 / max and the point is blanked
//     undefined : results wrap to the low COORD_W bits, blank as stored in ROM
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 1-cycle request, honoured only while idle
//   adr_start             first ROM word of the image
//   pos_x, pos_y          screen position of the image mid-point
//   mid_x, mid_y          image-local mid-point
//   busy                  high from accepted start until the run finishes
//   done                  1-cycle pulse when the image is finished
//   err_overrun           sticky overrun flag, cleared by the next start
//   rom_adr               registered ROM address
//   rom_data              {end, blank, px, py}, 1-cycle read latency
//   pt_x, pt_y, pt_blank  translated point and beam-off flag
//   pt_valid, pt_ready    point handshake
module img_vector_reader #(
  parameter int ADR_W      = 10,
  parameter int COORD_W    = 8,
  parameter int MAX_POINTS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADR_W-1:0]     adr_start,
  input  logic [COORD_W-1:0]   pos_x,
  input  logic [COORD_W-1:0]   pos_y,
  input  logic [COORD_W-1:0]   mid_x,
  input  logic [COORD_W-1:0]   mid_y,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overrun,
  output logic [ADR_W-1:0]     rom_adr,
  input  logic [2*COORD_W+1:0] rom_data,
  output logic [COORD_W-1:0]   pt_x,
  output logic [COORD_W-1:0]   pt_y,
  output logic                 pt_blank,
  output logic                 pt_valid,
  input  logic                 pt_ready
);

  localparam int CNT_W = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_OUT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [COORD_W-1:0] pos_x_q, pos_y_q, mid_x_q, mid_y_q;
  logic [CNT_W-1:0]   count;
  logic               end_q;

  logic               rom_end, rom_blank;
  logic [COORD_W-1:0] rom_px, rom_py;
  logic [COORD_W-1:0] x_n, y_n;
  logic               blank_n;
  logic               accept, last_pt, overrun_hit;

  assign rom_end   = rom_data[2*COORD_W+1];
  assign rom_blank = rom_data[2*COORD_W];
  assign rom_px    = rom_data[2*COORD_W-1:COORD_W];
  assign rom_py    = rom_data[COORD_W-1:0];

`ifdef IMG_READER_CLIP_EN
  localparam int S_W = COORD_W + 2;
  logic [S_W-1:0] sx, sy;
  logic           oob_x, oob_y;

  // Two guard bits hold -max..2*max exactly: top bit = negative,
  // next bit (with top clear) = above the screen.
  always_comb begin
    sx = {2'b00, pos_x_q} + {2'b00, rom_px} - {2'b00, mid_x_q};
    sy = {2'b00, pos_y_q} + {2'b00, rom_py} - {2'b00, mid_y_q};
    oob_x = sx[S_W-1] | sx[S_W-2];
    oob_y = sy[S_W-1] | sy[S_W-2];
    if (sx[S_W-1])      x_n = '0;
    else if (sx[S_W-2]) x_n = '1;
    else                x_n = sx[COORD_W-1:0];
    if (sy[S_W-1])      y_n = '0;
    else if (sy[S_W-2]) y_n = '1;
    else                y_n = sy[COORD_W-1:0];
    blank_n = rom_blank | oob_x | oob_y;
  end
`else
  // Wrapping result equals the low bits of the wide sum, so the guard
  // bits are never formed here.
  always_comb begin
    x_n     = pos_x_q + rom_px - mid_x_q;
    y_n     = pos_y_q + rom_py - mid_y_q;
    blank_n = rom_blank;
  end
`endif

  assign accept      = (state == S_OUT) && pt_ready;
  assign overrun_hit = (count == CNT_W'(MAX_POINTS - 1));
  assign last_pt     = end_q || overrun_hit;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_FETCH;
      S_FETCH: state_n = S_CAPT;
      S_CAPT:  state_n = S_OUT;
      S_OUT:   if (accept) state_n = last_pt ? S_DONE : S_FETCH;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
      rom_adr     <= '0;
      pt_x        <= '0;
      pt_y        <= '0;
      pt_blank    <= 1'b0;
      pt_valid    <= 1'b0;
      count       <= '0;
      end_q       <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      mid_x_q     <= '0;
      mid_y_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pos_x_q     <= pos_x;
            pos_y_q     <= pos_y;
            mid_x_q     <= mid_x;
            mid_y_q     <= mid_y;
            rom_adr     <= adr_start;
            count       <= '0;
            err_overrun <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_CAPT: begin
          pt_x     <= x_n;
          pt_y     <= y_n;
          pt_blank <= blank_n;
          end_q    <= rom_end;
          pt_valid <= 1'b1;
        end
        S_OUT: begin
          if (accept) begin
            pt_valid <= 1'b0;
            if (last_pt) begin
              done <= 1'b1;
              if (!end_q) err_overrun <= 1'b1;
            end else begin
              rom_adr <= rom_adr + ADR_W'(1);
              count   <= count + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_vector_reader.sv
module tb_img_vector_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  adr_start;
  logic [7:0]  pos_x, pos_y, mid_x, mid_y;
  logic        busy, done, err_overrun;
  logic [9:0]  rom_adr;
  logic [17:0] rom_data;
  logic [7:0]  pt_x, pt_y;
  logic        pt_blank, pt_valid, pt_ready;

  logic [17:0] rom [0:1023];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_adr];

  img_vector_reader #(.ADR_W(10), .COORD_W(8), .MAX_POINTS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .adr_start(adr_start),
    .pos_x(pos_x), .pos_y(pos_y), .mid_x(mid_x), .mid_y(mid_y),
    .busy(busy), .done(done), .err_overrun(err_overrun),
    .rom_adr(rom_adr), .rom_data(rom_data),
    .pt_x(pt_x), .pt_y(pt_y), .pt_blank(pt_blank),
    .pt_valid(pt_valid), .pt_ready(pt_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    int n = 0;
    while (!pt_valid && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, pt_valid}, 32'd1);
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int n = 0;
    while (!done && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int npts;
    int last_x;
    bit got_done;

    rst_n = 1'b0; start = 1'b0; pt_ready = 1'b1;
    adr_start = '0; pos_x = '0; pos_y = '0; mid_x = '0; mid_y = '0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[54]  = {1'b0, 1'b1, 8'd40, 8'd40};
    rom[55]  = {1'b0, 1'b0, 8'd50, 8'd40};
    rom[56]  = {1'b1, 1'b0, 8'd50, 8'd50};
    rom[100] = {1'b1, 1'b0, 8'd0,  8'd0};
    for (int i = 0; i < 70; i++) rom[200 + i] = {2'b00, 8'(i), 8'(i)};

    // reset state
    tick(); tick();
    chk("rst_busy",  {31'd0, busy},        32'd0);
    chk("rst_done",  {31'd0, done},        32'd0);
    chk("rst_valid", {31'd0, pt_valid},    32'd0);
    chk("rst_blank", {31'd0, pt_blank},    32'd0);
    chk("rst_err",   {31'd0, err_overrun}, 32'd0);
    chk("rst_adr",   {22'd0, rom_adr},     32'd0);
    chk("rst_x",     {24'd0, pt_x},        32'd0);
    chk("rst_y",     {24'd0, pt_y},        32'd0);
    rst_n = 1'b1;
    tick();

    // three-point image, ready high, exact latency
    adr_start = 10'd54; pos_x = 8'd100; pos_y = 8'd100; mid_x = 8'd45; mid_y = 8'd45;
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    chk("e0_busy",  {31'd0, busy},     32'd1);
    chk("e0_valid", {31'd0, pt_valid}, 32'd0);
    chk("e0_adr",   {22'd0, rom_adr},  32'd54);
    tick();                                   // E1
    chk("e1_valid", {31'd0, pt_valid}, 32'd0);
    tick();                                   // E2
    chk("p1_valid", {31'd0, pt_valid}, 32'd1);
    chk("p1_x",     {24'd0, pt_x},     32'd95);
    chk("p1_y",     {24'd0, pt_y},     32'd95);
    chk("p1_blank", {31'd0, pt_blank}, 32'd1);
    tick();                                   // E3 accept
    chk("a1_valid", {31'd0, pt_valid}, 32'd0);
    chk("a1_adr",   {22'd0, rom_adr},  32'd55);
    start = 1'b1;                             // start while busy
    tick();                                   // E4
    start = 1'b0;
    chk("busy_start_adr", {22'd0, rom_adr}, 32'd55);
    tick();                                   // E5
    chk("p2_valid", {31'd0, pt_valid}, 32'd1);
    chk("p2_x",     {24'd0, pt_x},     32'd105);
    chk("p2_y",     {24'd0, pt_y},     32'd95);
    chk("p2_blank", {31'd0, pt_blank}, 32'd0);
    tick();                                   // E6
    chk("a2_adr", {22'd0, rom_adr}, 32'd56);
    tick();                                   // E7
    tick();                                   // E8
    chk("p3_valid", {31'd0, pt_valid}, 32'd1);
    chk("p3_x",     {24'd0, pt_x},     32'd105);
    chk("p3_y",     {24'd0, pt_y},     32'd105);
    chk("p3_blank", {31'd0, pt_blank}, 32'd0);
    chk("p3_nodone", {31'd0, done},    32'd0);
    tick();                                   // E9 last accept
    chk("done_pulse", {31'd0, done},     32'd1);
    chk("done_valid", {31'd0, pt_valid}, 32'd0);
    start = 1'b1;                             // start in the DONE cycle
    tick();                                   // E10
    chk("done_once",      {31'd0, done}, 32'd0);
    chk("done_start_ign", {31'd0, busy}, 32'd0);
    tick();                                   // E11: start one cycle after done
    start = 1'b0;
    chk("restart_busy", {31'd0, busy}, 32'd1);

    // same image again, backpressure on point 2
    pt_ready = 1'b0;
    tick(); tick();
    chk("bp_p1_valid", {31'd0, pt_valid}, 32'd1);
    chk("bp_p1_x",     {24'd0, pt_x},     32'd95);
    pt_ready = 1'b1;
    tick();
    chk("bp_a1_valid", {31'd0, pt_valid}, 32'd0);
    pt_ready = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", {31'd0, pt_valid}, 32'd1);
      chk("bp_hold_x",     {24'd0, pt_x},     32'd105);
      chk("bp_hold_y",     {24'd0, pt_y},     32'd95);
      chk("bp_hold_blank", {31'd0, pt_blank}, 32'd0);
      chk("bp_hold_adr",   {22'd0, rom_adr},  32'd55);
      tick();
    end
    pt_ready = 1'b1;
    tick();
    chk("bp_a2_valid", {31'd0, pt_valid}, 32'd0);
    chk("bp_a2_adr",   {22'd0, rom_adr},  32'd56);
    wait_valid(6, "bp_p3_wait");
    chk("bp_p3_x", {24'd0, pt_x}, 32'd105);
    chk("bp_p3_y", {24'd0, pt_y}, 32'd105);
    tick();
    chk("bp_done", {31'd0, done}, 32'd1);
    tick();
    chk("bp_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of OUT
    pt_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(6, "mr_wait");
    rst_n = 1'b0;
    tick();
    chk("mr_valid", {31'd0, pt_valid}, 32'd0);
    chk("mr_busy",  {31'd0, busy},     32'd0);
    chk("mr_adr",   {22'd0, rom_adr},  32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("mr_nodone", {31'd0, done}, 32'd0);
      tick();
    end
    rst_n = 1'b1;
    pt_ready = 1'b1;
    tick();
    chk("mr_after_nodone", {31'd0, done}, 32'd0);

    // single-point image with off-screen translation
    adr_start = 10'd100; pos_x = 8'd10; pos_y = 8'd10; mid_x = 8'd32; mid_y = 8'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(6, "oob_wait");
`ifdef IMG_READER_CLIP_EN
    chk("oob_x",     {24'd0, pt_x},     32'd0);
    chk("oob_y",     {24'd0, pt_y},     32'd0);
    chk("oob_blank", {31'd0, pt_blank}, 32'd1);
`else
    chk("oob_x",     {24'd0, pt_x},     32'd234);
    chk("oob_y",     {24'd0, pt_y},     32'd226);
    chk("oob_blank", {31'd0, pt_blank}, 32'd0);
`endif
    tick();
    chk("single_valid", {31'd0, pt_valid}, 32'd0);
    chk("single_done",  {31'd0, done},     32'd1);
    chk("single_err",   {31'd0, err_overrun}, 32'd0);
    tick();
    chk("single_idle", {31'd0, busy}, 32'd0);

    // runaway image without end flag
    adr_start = 10'd200; pos_x = 8'd0; pos_y = 8'd0; mid_x = 8'd0; mid_y = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    npts = 0; last_x = -1; got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      tick();
      if (pt_valid) begin
        npts++;
        last_x = int'(pt_x);
      end
      if (done) got_done = 1'b1;
    end
    chk("ovr_done",   {31'd0, got_done},    32'd1);
    chk("ovr_points", npts,                 32'd64);
    chk("ovr_last_x", last_x,               32'd63);
    chk("ovr_err",    {31'd0, err_overrun}, 32'd1);
    tick();
    chk("ovr_err_sticky", {31'd0, err_overrun}, 32'd1);
    chk("ovr_idle",       {31'd0, busy},        32'd0);
    tick();
    chk("ovr_err_hold", {31'd0, err_overrun}, 32'd1);
    adr_start = 10'd54; pos_x = 8'd100; pos_y = 8'd100; mid_x = 8'd45; mid_y = 8'd45;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovr_err_clr", {31'd0, err_overrun}, 32'd0);
    chk("ovr_restart", {31'd0, busy},        32'd1);
    wait_done(30, "final_done");
    tick();
    chk("final_err", {31'd0, err_overrun}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
